mux: RTL and testbench

MUX -- requirements
Module: mux

---
 rtl/mux.sv | 105 ++++++++++
 tb/tb_mux.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux.sv
// -----------------------------------------------------------------------------
// mux -- 2:1 flit multiplexer with a single registered output stage.
//
// Purpose
//   Forwards the flit of the selected input port to the output one clock after
//   it is sampled. There is no flow control and no buffering beyond the output
//   register. Flit type bits [DATAW-1:DATAW-2] are carried through untouched.
//
// Valid semantics
//   ivalid_N qualifies idata_N/ivch_N in the cycle it is high. There is no
//   ready: every valid flit on the selected port is captured at the next
//   rising edge. ovalid qualifies odata/ovch. Whenever ovalid is 0, odata and
//   ovch are forced to 0 so that invalid payload never toggles the output bus.
//
// Ports
//   clk       clock; all state changes on its rising edge
//   rst_      asynchronous active-low reset; clears all outputs immediately
//   idata_0   port 0 flit         ivalid_0  port 0 valid   ivch_0  port 0 VC id
//   idata_1   port 1 flit         ivalid_1  port 1 valid   ivch_1  port 1 VC id
//   sel       one-hot select: bit0 = port 0, bit1 = port 1 (bit0 wins when
//             both are set); bits [PORTW-1:2] are reserved and ignored
//   odata     registered selected flit
//   ovalid    registered selected valid
//   ovch      registered selected VC id
// -----------------------------------------------------------------------------
module mux #(
  parameter int DATAW = 66,
  parameter int VCHW  = 2,
  parameter int PORTW = 5
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW-1:0] idata_0,
  input  logic             ivalid_0,
  input  logic [VCHW-1:0]  ivch_0,
  input  logic [DATAW-1:0] idata_1,
  input  logic             ivalid_1,
  input  logic [VCHW-1:0]  ivch_1,
  input  logic [PORTW-1:0] sel,
  output logic [DATAW-1:0] odata,
  output logic             ovalid,
  output logic [VCHW-1:0]  ovch
);

  // Reserved select bits are deliberately not decoded.
  generate
    if (PORTW > 2) begin : g_sel_reserved
      logic sel_reserved_unused;
      assign sel_reserved_unused = ^sel[PORTW-1:2];
    end
  endgenerate

  // Decoded grants: port 0 has priority over port 1.
  logic pick_0;
  logic pick_1;
  logic take_0;
  logic take_1;

  logic [DATAW-1:0] odata_d;
  logic             ovalid_d;
  logic [VCHW-1:0]  ovch_d;

  logic [DATAW-1:0] odata_q;
  logic             ovalid_q;
  logic [VCHW-1:0]  ovch_q;

  always_comb begin
    pick_0 = sel[0];
    pick_1 = ~sel[0] & sel[1];
    take_0 = pick_0 & ivalid_0;
    take_1 = pick_1 & ivalid_1;

    // Default is the idle (all-zero) output; only a valid flit on the
    // selected port overrides it.
    odata_d  = '0;
    ovalid_d = 1'b0;
    ovch_d   = '0;
    if (take_0) begin
      odata_d  = idata_0;
      ovalid_d = 1'b1;
      ovch_d   = ivch_0;
    end else if (take_1) begin
      odata_d  = idata_1;
      ovalid_d = 1'b1;
      ovch_d   = ivch_1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
    end else begin
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovch_q   <= ovch_d;
    end
  end

  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign ovch   = ovch_q;

endmodule

// File: tb/tb_mux.sv
module tb_mux;

  localparam int DATAW = 66;
  localparam int VCHW  = 2;
  localparam int PORTW = 5;
  localparam int W     = 1 + VCHW + DATAW;

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_DATA = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_NONE = 2'b11;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  logic [DATAW-1:0] idata_0, idata_1, odata;
  logic             ivalid_0, ivalid_1, ovalid;
  logic [VCHW-1:0]  ivch_0, ivch_1, ovch;
  logic [PORTW-1:0] sel;

  mux #(.DATAW(DATAW), .VCHW(VCHW), .PORTW(PORTW)) dut (
    .clk(clk), .rst_(rst_),
    .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
    .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
    .sel(sel), .odata(odata), .ovalid(ovalid), .ovch(ovch)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the selected port is the lowest set bit among sel[1:0];
  // the output shows that port's flit only if it is valid, otherwise all zero.
  function automatic logic [W-1:0] ref_out();
    logic [DATAW-1:0] d[2];
    logic             v[2];
    logic [VCHW-1:0]  c[2];
    int pick;
    d[0] = idata_0; v[0] = ivalid_0; c[0] = ivch_0;
    d[1] = idata_1; v[1] = ivalid_1; c[1] = ivch_1;
    pick = -1;
    for (int p = 0; p < 2; p++)
      if (pick < 0 && sel[p]) pick = p;
    if (!rst_ || pick < 0 || !v[pick]) return '0;
    return {1'b1, c[pick], d[pick]};
  endfunction

  // ---------------------------------------------------------------- drivers
  function automatic logic [DATAW-1:0] rand_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DATAW-1:0] flit(input logic [1:0] t, input logic [63:0] payload);
    return {t, payload};
  endfunction

  // One clock: predict at the edge from the stable inputs, check #1 later.
  task automatic cycle(input string tag);
    logic [W-1:0] e;
    @(posedge clk);
    exp_q.push_back(ref_out());
    #1;
    e = exp_q.pop_front();
    check_eq(tag, {ovalid, ovch, odata}, e);
  endtask

  task automatic rand_port0();
    idata_0  = rand_data();
    ivalid_0 = 1'($urandom_range(0, 1));
    ivch_0   = VCHW'($urandom_range(0, 3));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [63:0] pat;

    // Reset with a valid selected port: outputs must stay zero.
    rst_ = 1'b0;
    sel = 5'b00001; ivalid_0 = 1'b1; idata_0 = rand_data(); ivch_0 = 2'd3;
    ivalid_1 = 1'b0; idata_1 = '0; ivch_1 = '0;
    #1;
    check_eq("reset_async_t0", {ovalid, ovch, odata}, '0);
    for (int i = 0; i < 3; i++) cycle("reset_hold");

    rst_ = 1'b1;
    cycle("first_capture");

    // Port 1 packet with concurrent random port 0 traffic.
    sel = 5'b00010; ivalid_1 = 1'b1; ivch_1 = 2'd1;
    for (int pkt = 0; pkt < 2; pkt++) begin
      ivalid_1 = 1'b1;
      idata_1 = flit(T_HEAD, 64'h4);
      rand_port0();
      cycle("p1_head");
      for (int i = 0; i < 20; i++) begin
        if (i == 0) pat = 64'h380;
        else if (i == 1) pat = 64'h3F0;
        else pat = 64'($urandom_range(0, 1023));
        idata_1 = flit(T_DATA, pat);
        rand_port0();
        cycle("p1_payload");
      end
      idata_1 = flit(T_TAIL, 64'h3FF);
      rand_port0();
      cycle("p1_tail");
      // Gap between packets.
      for (int i = 0; i < 7; i++) begin
        ivalid_1 = 1'b0;
        idata_1 = rand_data();
        rand_port0();
        cycle("p1_gap");
      end
    end

    // NONE-type flit passes unmodified.
    ivalid_1 = 1'b1; idata_1 = flit(T_NONE, 64'hDEAD_BEEF);
    cycle("type_none");

    // Priority: both bits set, both valid.
    sel = 5'b00011;
    ivalid_0 = 1'b1; idata_0 = flit(T_HEAD, 64'h1111); ivch_0 = 2'd2;
    ivalid_1 = 1'b1; idata_1 = flit(T_HEAD, 64'h2222); ivch_1 = 2'd1;
    cycle("prio_both");
    // Only reserved bits set: nothing selected.
    sel = 5'b11100;
    cycle("reserved_only");

    // Mid-packet switch from port 0 to port 1.
    sel = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      idata_0 = flit(i == 0 ? T_HEAD : T_DATA, 64'(i + 16'h100));
      cycle("switch_p0");
    end
    sel = 5'b00010;
    for (int i = 0; i < 3; i++) begin
      idata_1 = flit(T_DATA, 64'(i + 16'h200));
      cycle("switch_p1");
    end

    // Selected port invalid: data must not leak.
    sel = 5'b00001; ivalid_0 = 1'b0; idata_0 = 66'h1234;
    cycle("sel_invalid");

    // Asynchronous reset between edges, mid-packet.
    ivalid_0 = 1'b1; idata_0 = flit(T_DATA, 64'hABCD);
    cycle("pre_async");
    #2 rst_ = 1'b0;
    #1 check_eq("async_assert", {ovalid, ovch, odata}, '0);
    cycle("async_hold");
    rst_ = 1'b1;
    cycle("async_release");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      sel = PORTW'($urandom_range(0, 31));
      rand_port0();
      idata_1  = rand_data();
      ivalid_1 = 1'($urandom_range(0, 1));
      ivch_1   = VCHW'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) begin
        #2 rst_ = 1'b0;
        #1 check_eq("rand_async", {ovalid, ovch, odata}, '0);
      end else begin
        rst_ = 1'b1;
      end
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
